// File: rtl/peak_report_uart.sv
// peak_report_uart: sends the peak-search results to the host as a fixed 8N1 UART packet
//   params : BAUD_DIV  clock cycles per UART bit (2..65535)
//   inputs : clk, rst_n (async, active-low), message/message1 (33-bit result words), frame_done (accept pulse)
//   outputs: uart_tx (idle high), busy, pkt_done (one cycle at packet end), drop_cnt (saturating ignored-pulse count)
//   define PEAK_REPORT_CHECKSUM_EN to append the XOR checksum byte B11 (12-byte packet, otherwise 11 bytes)
module peak_report_uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [32:0] message,
    input  logic [32:0] message1,
    input  logic        frame_done,
    output logic        uart_tx,
    output logic        busy,
    output logic        pkt_done,
    output logic [7:0]  drop_cnt
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`ifdef PEAK_REPORT_CHECKSUM_EN
    localparam logic [3:0] LAST = 4'd11;
`else
    localparam logic [3:0] LAST = 4'd10;
`endif
    localparam logic [15:0] BAUD_LD = 16'(BAUD_DIV - 1);
    state_t      state_q, state_d;
    logic [87:0] shadow_q, shadow_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] baud_q, baud_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  drop_q, drop_d;
    logic [87:0] sh_sel;
    logic [7:0]  cur_byte;
`ifdef PEAK_REPORT_CHECKSUM_EN
    logic [7:0]  csum;
`endif
    // shadow holds B0..B10 MSB-first, so shifting by the byte index brings the current byte to the top
    always_comb begin
        sh_sel   = shadow_q << {idx_q, 3'b000};
        cur_byte = sh_sel[87:80];
`ifdef PEAK_REPORT_CHECKSUM_EN
        csum = 8'h00;
        for (int i = 0; i < 9; i++) csum = csum ^ shadow_q[8*i +: 8];
        if (idx_q == 4'd11) cur_byte = csum;
`endif
    end
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        bit_d    = bit_q;
        baud_d   = (baud_q == 16'd0) ? BAUD_LD : baud_q - 16'd1;
        shift_d  = shift_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = baud_q;
                if (frame_done) begin
                    state_d  = START;
                    shadow_d = {8'hA5, 8'h5A, 6'b0, message1[32], message[32], message[31:0], message1[31:0]};
                    idx_d    = 4'd0;
                    bit_d    = 3'd0;
                    baud_d   = BAUD_LD;
                end
            end
            START: if (baud_q == 16'd0) begin
                state_d = DATA;
                shift_d = cur_byte;
                bit_d   = 3'd0;
            end
            DATA: if (baud_q == 16'd0) begin
                state_d = (bit_q == 3'd7) ? STOP : DATA;
                bit_d   = bit_q + 3'd1;
                shift_d = shift_q >> 1;
            end
            STOP: if (baud_q == 16'd0) begin
                state_d = (idx_q == LAST) ? IDLE : START;
                idx_d   = (idx_q == LAST) ? idx_q : idx_q + 4'd1;
                done_d  = (idx_q == LAST);
            end
            default: state_d = IDLE;
        endcase
        // line and busy are registered from the next state so they change on the same edge as the FSM
        tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
        busy_d = (state_d != IDLE);
        drop_d = (frame_done && state_q != IDLE && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            bit_q    <= '0;
            baud_q   <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end
    assign uart_tx  = tx_q;
    assign busy     = busy_q;
    assign pkt_done = done_q;
    assign drop_cnt = drop_q;
endmodule

// File: tb/tb_peak_report_uart.sv
// tb_peak_report_uart: self-checking bench for peak_report_uart with a UART receiver and packet model
module tb_peak_report_uart;
    localparam int BD = 4;
`ifdef PEAK_REPORT_CHECKSUM_EN
    localparam int NB = 12;
`else
    localparam int NB = 11;
`endif
    localparam int PKT = NB * 10 * BD;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [32:0] message = '0;
    logic [32:0] message1 = '0;
    logic        frame_done = 1'b0;
    logic        uart_tx, busy, pkt_done;
    logic [7:0]  drop_cnt;
    int total = 0;
    int bad = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int abort_gen = 0;
    int dec_gen;
    logic [7:0] dec_b;

    peak_report_uart #(.BAUD_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .message(message), .message1(message1),
        .frame_done(frame_done), .uart_tx(uart_tx), .busy(busy), .pkt_done(pkt_done), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(negedge rst_n) abort_gen++;

    // receiver: detect start bit, sample each bit in its middle, require a valid stop bit
    initial forever begin
        @(negedge clk);
        if (rst_n && uart_tx === 1'b0) begin
            dec_gen = abort_gen;
            for (int k = 0; k < 8; k++) begin
                repeat (k == 0 ? BD + BD / 2 : BD) @(negedge clk);
                dec_b[k] = uart_tx;
            end
            repeat (BD) @(negedge clk);
            if (uart_tx === 1'b1 && dec_gen == abort_gen && rst_n) rx_q.push_back(dec_b);
        end
    end

    task automatic build_exp(input logic [32:0] m0, input logic [32:0] m1);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back({6'b0, m1[32], m0[32]});
        for (int k = 3; k >= 0; k--) exp_q.push_back(m0[8*k +: 8]);
        for (int k = 3; k >= 0; k--) exp_q.push_back(m1[8*k +: 8]);
        x = 8'h00;
        for (int i = 2; i <= 10; i++) x = x ^ exp_q[i];
        if (NB == 12) exp_q.push_back(x);
    endtask

    task automatic do_reset();
        frame_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_q.delete();
    endtask

    task automatic accept(input logic [32:0] m0, input logic [32:0] m1);
        @(negedge clk);
        message = m0;
        message1 = m1;
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    task automatic wait_pkt(output int bc, output int dc, output bit fell, output bit at_fall);
        bc = 0; dc = 0; fell = 0; at_fall = 0;
        for (int i = 0; i < 4 * PKT && !fell; i++) begin
            if (busy) bc++;
            else begin
                fell = 1;
                at_fall = pkt_done;
            end
            if (pkt_done) dc++;
            if (!fell) @(negedge clk);
        end
        repeat (5) begin
            @(negedge clk);
            if (pkt_done) dc++;
        end
    endtask

    task automatic test_reset();
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", uart_tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (pkt_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", pkt_done); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
    endtask

    task automatic test_basic();
        int bc, dc; bit fell, af;
        rx_q.delete();
        build_exp({1'b1, 32'd12500}, {1'b0, 32'd5000});
        accept({1'b1, 32'd12500}, {1'b0, 32'd5000});
        total++; if (busy !== 1'b1 || uart_tx !== 1'b0) begin bad++; $display("FAIL basic_latency busy=%b tx=%b want 1,0", busy, uart_tx); end
        wait_pkt(bc, dc, fell, af);
        total++; if (!fell) begin bad++; $display("FAIL basic_timeout busy never fell"); end
        total++; if (bc != PKT) begin bad++; $display("FAIL basic_busy_len got=%0d want=%0d", bc, PKT); end
        total++; if (dc != 1 || !af) begin bad++; $display("FAIL basic_pkt_done pulses=%0d at_fall=%b want 1,1", dc, af); end
        total++; if (rx_q.size() != NB) begin bad++; $display("FAIL basic_len got=%0d want=%0d", rx_q.size(), NB); end
        for (int i = 0; i < NB && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
        end
        if (NB == 12 && rx_q.size() == 12) begin
            total++; if (rx_q[11] !== 8'h7E) begin bad++; $display("FAIL basic_csum got=%h want=7e", rx_q[11]); end
        end
    endtask

    task automatic test_bit_timing();
        logic [9:0] line;
        logic [39:0] obs;
        int bc, dc; bit fell, af;
        line = 10'b1101001010;
        accept({1'b0, 32'h0}, {1'b0, 32'h0});
        for (int c = 0; c < 40; c++) begin
            obs[c] = uart_tx;
            @(negedge clk);
        end
        for (int j = 0; j < 10; j++) begin
            total++;
            if (obs[4*j +: 4] !== {4{line[j]}}) begin
                bad++; $display("FAIL bit%0d_width got=%b want=%b", j, obs[4*j +: 4], {4{line[j]}});
            end
        end
        wait_pkt(bc, dc, fell, af);
    endtask

    task automatic test_snapshot();
        int bc, dc; bit fell, af;
        rx_q.delete();
        build_exp({1'b1, 32'd12500}, {1'b0, 32'd5000});
        accept({1'b1, 32'd12500}, {1'b0, 32'd5000});
        repeat (10) @(negedge clk);
        message = {1'b0, 32'd7500};
        message1 = {1'b1, 32'hFFFF_FFFF};
        wait_pkt(bc, dc, fell, af);
        total++; if (rx_q.size() != NB) begin bad++; $display("FAIL snap_len got=%0d want=%0d", rx_q.size(), NB); end
        for (int i = 0; i < NB && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL snap_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_drops();
        int bc, dc; bit fell, af;
        do_reset();
        build_exp({1'b0, 32'hDEAD_BEEF}, {1'b1, 32'h0102_0304});
        accept({1'b0, 32'hDEAD_BEEF}, {1'b1, 32'h0102_0304});
        fork
            wait_pkt(bc, dc, fell, af);
            begin
                for (int c = 1; c < PKT; c++) begin
                    @(negedge clk);
                    frame_done = (c == 50 || c == 100 || c == 150 || c == PKT - 1);
                end
                @(negedge clk);
                frame_done = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        total++; if (drop_cnt !== 8'd4) begin bad++; $display("FAIL drop_count got=%0d want=4", drop_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_restart busy=%b want=0", busy); end
        total++; if (dc != 1) begin bad++; $display("FAIL drop_pkts pulses=%0d want=1", dc); end
        total++; if (rx_q.size() != NB) begin bad++; $display("FAIL drop_len got=%0d want=%0d", rx_q.size(), NB); end
        for (int i = 0; i < NB && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL drop_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_saturate();
        int bc, dc; bit fell, af;
        do_reset();
        accept({1'b1, 32'd1}, {1'b1, 32'd2});
        fork
            wait_pkt(bc, dc, fell, af);
            begin
                for (int c = 1; c < PKT; c++) begin
                    @(negedge clk);
                    if (c == 201) begin
                        total++; if (drop_cnt !== 8'd200) begin bad++; $display("FAIL sat_mid got=%0d want=200", drop_cnt); end
                    end
                    frame_done = (c <= 300);
                end
                frame_done = 1'b0;
            end
        join
        total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d want=255", drop_cnt); end
        total++; if (dc != 1 || bc != PKT) begin bad++; $display("FAIL sat_pkt pulses=%0d busy=%0d want 1,%0d", dc, bc, PKT); end
    endtask

    task automatic test_reset_mid();
        int bc, dc; bit fell, af;
        accept({1'b1, 32'h1234_5678}, {1'b0, 32'h9ABC_DEF0});
        repeat (5 * 10 * BD + 1) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_abort tx=%b busy=%b want 1,0", uart_tx, busy); end
        dc = 0;
        repeat (3) begin @(negedge clk); if (pkt_done) dc++; end
        rst_n = 1'b1;
        repeat (60) begin @(negedge clk); if (pkt_done) dc++; end
        total++; if (dc != 0 || busy !== 1'b0) begin bad++; $display("FAIL rst_no_done pulses=%0d busy=%b want 0,0", dc, busy); end
        rx_q.delete();
        build_exp({1'b1, 32'd12500}, {1'b0, 32'd5000});
        accept({1'b1, 32'd12500}, {1'b0, 32'd5000});
        wait_pkt(bc, dc, fell, af);
        total++; if (bc != PKT || dc != 1) begin bad++; $display("FAIL rst_next busy=%0d pulses=%0d want %0d,1", bc, dc, PKT); end
        total++; if (rx_q.size() != NB) begin bad++; $display("FAIL rst_len got=%0d want=%0d", rx_q.size(), NB); end
        for (int i = 0; i < NB && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL rst_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int bc, dc; bit fell, af;
        logic [32:0] m0, m1;
        for (int n = 0; n < 4; n++) begin
            m0 = {($urandom_range(0, 1) == 1), 32'($urandom())};
            m1 = {($urandom_range(0, 1) == 1), 32'($urandom())};
            rx_q.delete();
            build_exp(m0, m1);
            accept(m0, m1);
            message = {1'b0, 32'($urandom())};
            wait_pkt(bc, dc, fell, af);
            total++; if (bc != PKT || dc != 1 || !af) begin bad++; $display("FAIL rand%0d_timing busy=%0d pulses=%0d at_fall=%b", n, bc, dc, af); end
            total++; if (rx_q.size() != NB) begin bad++; $display("FAIL rand%0d_len got=%0d want=%0d", n, rx_q.size(), NB); end
            for (int i = 0; i < NB && i < rx_q.size(); i++) begin
                total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_byte%0d got=%h want=%h", n, i, rx_q[i], exp_q[i]); end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_basic();
        test_bit_timing();
        test_snapshot();
        test_random();
        test_drops();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
